// File: rtl/sram_arbiter_if.sv
// Request/response and SRAM strobe bundle for sram_arbiter.
// master: requesters plus SRAM model; slave: the arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic                sram_read;
  logic                sram_write;
  logic [ADDR_W-1:0]   sram_address;
  logic [DATA_W-1:0]   sram_wdata;
  logic [DATA_W-1:0]   sram_rdata;

  modport master (
    output req, we, addr, wdata, sram_rdata,
    input  gnt, rvalid, rdata, busy,
    input  sram_read, sram_write,
    input  sram_address, sram_wdata
  );

  modport slave (
    input  req, we, addr, wdata, sram_rdata,
    output gnt, rvalid, rdata, busy,
    output sram_read, sram_write,
    output sram_address, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Three-way arbiter for the single-port pixel SRAM.
// Define SRAM_ARB_RR_EN for round-robin; default is fixed priority.
module sram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input logic           clk,
  input logic           n_rst,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT
  } state_t;

  state_t              state_q;
  logic [2:0]          gnt_q;
  logic [2:0]          own_q;
  logic [2:0]          rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rd_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          cnt_q;
  logic [1:0]          ptr;
  logic [1:0]          win;
  logic [2:0]          s;

`ifdef SRAM_ARB_RR_EN
  logic [1:0] ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = 2'd0;
`endif

  // Walk the search order backwards so the first hit from ptr wins.
  always_comb begin
    win = 2'd0;
    s   = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      s = {1'b0, ptr} + 3'(k);
      if (s > 3'd2) s = s - 3'd3;
      if (bus.req[s[1:0]]) win = s[1:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      own_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
`ifdef SRAM_ARB_RR_EN
      ptr_q    <= 2'd0;
`endif
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q <= ACCESS;
            gnt_q   <= 3'b001 << win;
            own_q   <= 3'b001 << win;
            addr_q  <= bus.addr[win*ADDR_W +: ADDR_W];
            wr_q    <= bus.we[win];
            rd_q    <= ~bus.we[win];
            if (bus.we[win])
              wdata_q <= bus.wdata[win*DATA_W +: DATA_W];
`ifdef SRAM_ARB_RR_EN
            ptr_q <= (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
          end
        end
        ACCESS: begin
          if (wr_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= 3'(READ_LAT - 1);
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 3'd0) begin
            rdata_q  <= bus.sram_rdata;
            rvalid_q <= own_q;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.sram_read    = rd_q;
  assign bus.sram_write   = wr_q;
  assign bus.sram_address = addr_q;
  assign bus.sram_wdata   = wdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench: two arbiters (READ_LAT 1 and 3) with SRAM models.
module tb_sram_arbiter;
  typedef struct {
    logic [2:0]  v;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } ev_t;

  logic clk;
  logic n_rst;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  gq[2][$];
  ev_t  rq[2][$];

  logic [7:0] mem1[65536];
  logic [7:0] mem3[65536];
  logic [7:0] p1;
  logic [7:0] p3[3];

  sram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) b1();
  sram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) b3();

  sram_arbiter #(.READ_LAT(1)) u1 (
    .clk(clk), .n_rst(n_rst), .bus(b1.slave));
  sram_arbiter #(.READ_LAT(3)) u3 (
    .clk(clk), .n_rst(n_rst), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (b1.sram_write) mem1[b1.sram_address] <= b1.sram_wdata;
    p1 <= mem1[b1.sram_address];
    if (b3.sram_write) mem3[b3.sram_address] <= b3.sram_wdata;
    p3[0] <= mem3[b3.sram_address];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.sram_rdata = p1;
  assign b3.sram_rdata = p3[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic pg(input int id, input logic [2:0] v, input logic wr,
                    input logic [15:0] a, input logic [7:0] d,
                    input int c);
    ev_t e;
    e.v = v; e.wr = wr; e.a = a; e.d = d; e.c = c;
    gq[id].push_back(e);
  endtask

  task automatic pr(input int id, input logic [2:0] v,
                    input logic [7:0] d, input int c);
    ev_t e;
    e.v = v; e.wr = 1'b0; e.a = '0; e.d = d; e.c = c;
    rq[id].push_back(e);
  endtask

  task automatic mon(input int id, input logic [2:0] g,
                     input logic [2:0] rv, input logic rd,
                     input logic wr, input logic [15:0] a,
                     input logic [7:0] wd, input logic [7:0] rdat);
    ev_t e;
    if (rd || wr) chk("strobe_excl", 32'(rd && wr), 32'd0);
    if (g != 3'b000) begin
      if (gq[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_gnt: dut%0d got %b, expected none (cycle %0d)",
                 id, g, cyc);
      end else begin
        e = gq[id].pop_front();
        chk("gnt", 32'(g), 32'(e.v));
        chk("gnt_cycle", 32'(cyc), 32'(e.c));
        chk("sram_write", 32'(wr), 32'(e.wr));
        chk("sram_read", 32'(rd), 32'(!e.wr));
        chk("sram_address", 32'(a), 32'(e.a));
        if (e.wr) chk("sram_wdata", 32'(wd), 32'(e.d));
      end
    end
    if (rv != 3'b000) begin
      if (rq[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: dut%0d got %b, expected none (cycle %0d)",
                 id, rv, cyc);
      end else begin
        e = rq[id].pop_front();
        chk("rvalid", 32'(rv), 32'(e.v));
        chk("rvalid_cycle", 32'(cyc), 32'(e.c));
        chk("rdata", 32'(rdat), 32'(e.d));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b1.gnt, b1.rvalid, b1.sram_read, b1.sram_write,
        b1.sram_address, b1.sram_wdata, b1.rdata);
    mon(1, b3.gnt, b3.rvalid, b3.sram_read, b3.sram_write,
        b3.sram_address, b3.sram_wdata, b3.rdata);
  end

  task automatic zchk(input string nm, input logic [2:0] g,
                      input logic [2:0] rv, input logic [7:0] rdat,
                      input logic bsy, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [7:0] wd);
    chk({nm, "_gnt"}, 32'(g), 32'd0);
    chk({nm, "_rvalid"}, 32'(rv), 32'd0);
    chk({nm, "_rdata"}, 32'(rdat), 32'd0);
    chk({nm, "_busy"}, 32'(bsy), 32'd0);
    chk({nm, "_rd"}, 32'(rd), 32'd0);
    chk({nm, "_wr"}, 32'(wr), 32'd0);
    chk({nm, "_addr"}, 32'(a), 32'd0);
    chk({nm, "_wdata"}, 32'(wd), 32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    mem1[16'h1388] = 8'h3C;
    mem3[16'h1388] = 8'h3C;
    n_rst = 1'b0;
    b1.req = '0; b1.we = '0; b1.addr = '0; b1.wdata = '0;
    b3.req = '0; b3.we = '0; b3.addr = '0; b3.wdata = '0;
    tick(3);
    zchk("rst1", b1.gnt, b1.rvalid, b1.rdata, b1.busy, b1.sram_read,
         b1.sram_write, b1.sram_address, b1.sram_wdata);
    zchk("rst3", b3.gnt, b3.rvalid, b3.rdata, b3.busy, b3.sram_read,
         b3.sram_write, b3.sram_address, b3.sram_wdata);
    n_rst = 1'b1;
    tick(1);

    // single write
    b1.req = 3'b001; b1.we = 3'b001;
    b1.addr[15:0] = 16'h0040; b1.wdata[7:0] = 8'hA5;
    pg(0, 3'b001, 1'b1, 16'h0040, 8'hA5, cyc + 1);
    tick(1);
    chk("wr_busy_access", 32'(b1.busy), 32'd1);
    b1.req = 3'b000;
    tick(1);
    chk("wr_busy_idle", 32'(b1.busy), 32'd0);

    // read, READ_LAT=1
    b1.req = 3'b100; b1.we = 3'b000; b1.addr[47:32] = 16'h1388;
    pg(0, 3'b100, 1'b0, 16'h1388, 8'h00, cyc + 1);
    pr(0, 3'b100, 8'h3C, cyc + 3);
    tick(1);
    b1.req = 3'b000;
    tick(4);

    // contention, each dropped after its grant
    b1.we = 3'b111;
    b1.addr = {16'h0102, 16'h0101, 16'h0100};
    b1.wdata = {8'h33, 8'h22, 8'h11};
    b1.req = 3'b111;
    pg(0, 3'b001, 1'b1, 16'h0100, 8'h11, cyc + 1);
    pg(0, 3'b010, 1'b1, 16'h0101, 8'h22, cyc + 3);
    pg(0, 3'b100, 1'b1, 16'h0102, 8'h33, cyc + 5);
    tick(1); b1.req[0] = 1'b0;
    tick(2); b1.req[1] = 1'b0;
    tick(2); b1.req[2] = 1'b0;
    tick(2);

    // all requests held continuously
    b1.req = 3'b111;
`ifdef SRAM_ARB_RR_EN
    pg(0, 3'b001, 1'b1, 16'h0100, 8'h11, cyc + 1);
    pg(0, 3'b010, 1'b1, 16'h0101, 8'h22, cyc + 3);
    pg(0, 3'b100, 1'b1, 16'h0102, 8'h33, cyc + 5);
    pg(0, 3'b001, 1'b1, 16'h0100, 8'h11, cyc + 7);
    tick(7);
`else
    pg(0, 3'b001, 1'b1, 16'h0100, 8'h11, cyc + 1);
    pg(0, 3'b001, 1'b1, 16'h0100, 8'h11, cyc + 3);
    tick(3);
`endif
    b1.req = 3'b000;
    tick(2);

    // early withdraw of req1 during a req0 read
    b1.we = 3'b000; b1.addr[15:0] = 16'h0040;
    b1.req = 3'b001;
    pg(0, 3'b001, 1'b0, 16'h0040, 8'h00, cyc + 1);
    pr(0, 3'b001, 8'hA5, cyc + 3);
    tick(1);
    b1.req = 3'b010; b1.we = 3'b010;
    tick(1);
    b1.req = 3'b000;
    tick(4);

    // reset in the middle of a read
    b1.we = 3'b000; b1.addr[47:32] = 16'h1388;
    b1.req = 3'b100;
    pg(0, 3'b100, 1'b0, 16'h1388, 8'h00, cyc + 1);
    tick(1);
    b1.req = 3'b000;
    tick(1);
    chk("midrst_pre_busy", 32'(b1.busy), 32'd1);
    n_rst = 1'b0;
    #1;
    zchk("midrst", b1.gnt, b1.rvalid, b1.rdata, b1.busy, b1.sram_read,
         b1.sram_write, b1.sram_address, b1.sram_wdata);
    tick(1);
    n_rst = 1'b1;
    tick(4);
    chk("postrst_busy", 32'(b1.busy), 32'd0);

    // READ_LAT=3 read with a write queued behind it
    b3.req = 3'b100; b3.we = 3'b000; b3.addr[47:32] = 16'h1388;
    pg(1, 3'b100, 1'b0, 16'h1388, 8'h00, cyc + 1);
    pr(1, 3'b100, 8'h3C, cyc + 5);
    tick(1);
    b3.req = 3'b000;
    tick(1);
    b3.req = 3'b001; b3.we = 3'b001;
    b3.addr[15:0] = 16'h0010; b3.wdata[7:0] = 8'h5A;
    pg(1, 3'b001, 1'b1, 16'h0010, 8'h5A, cyc + 4);
    tick(4);
    b3.req = 3'b000;
    tick(3);

    chk("queues_empty",
        32'(gq[0].size() + rq[0].size() + gq[1].size() + rq[1].size()),
        32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
